param_mod_counter: RTL and testbench

Parametrised modulo counter, next generation of the block-level up/down counters used in TOP-style control logic. Adds:
- configurable width and modulus
- bidirectional counting
- synchronous load, with out-of-range load values clamped
- wrap or saturate mode
- enable prescaler
- registered wrap pulse and wrap-event tally
Used wherever a bounded event/cycle counter with terminal detection is needed.

---
 rtl/pmc_pkg.sv | 32 +++
 rtl/pmc_prescaler.sv | 39 +++
 rtl/param_mod_counter.sv | 156 +++++++++++++++
 tb/tb_param_mod_counter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pmc_pkg.sv
// Shared types and helpers for the parametrised modulo counter.
package pmc_pkg;

   // Per-cycle step direction decoded from the two enable inputs.
   typedef enum logic [1:0] {
      DIR_IDLE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DN   = 2'd2
   } dir_e;

   // Widest internal arithmetic: WIDTH max 16, plus one guard bit.
   localparam int unsigned PMC_AW = 17;

   // Conflicting or absent requests both decode to idle.
   function automatic dir_e dir_decode(input logic up, input logic dn);
      dir_e d;
      d = DIR_IDLE;
      if (up && !dn) d = DIR_UP;
      else if (dn && !up) d = DIR_DN;
      return d;
   endfunction

   // Clamp a value into 0..modulus-1.
   function automatic logic [PMC_AW-1:0] clamp_mod(input logic [PMC_AW-1:0] value,
                                                   input logic [PMC_AW-1:0] modulus);
      logic [PMC_AW-1:0] r;
      r = value;
      if (value >= modulus) r = modulus - PMC_AW'(1);
      return r;
   endfunction

endpackage

// File: rtl/pmc_prescaler.sv
// Enable prescaler: emits one tick every PRESCALE active cycles.
// The phase holds on idle cycles and restarts from zero on clear.
module pmc_prescaler
   import pmc_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic CLK,
   input  logic RSTN,
   input  logic i_active,
   input  logic i_clear,
   output logic o_tick
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
      $fatal(1, "pmc_prescaler: PRESCALE out of range 1..256");
   end

   logic [PW-1:0] r_phase;

   assign o_tick = i_active & (r_phase == LAST);

   // Phase counter: advance on active cycles, restart on tick or clear.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_phase <= '0;
      end else if (i_clear) begin
         r_phase <= '0;
      end else if (o_tick) begin
         r_phase <= '0;
      end else if (i_active) begin
         r_phase <= r_phase + PW'(1);
      end
   end

endmodule

// File: rtl/param_mod_counter.sv
// Parametrised modulo counter with up/down stepping, clamped load,
// wrap or saturate boundaries, enable prescaler, registered wrap pulse
// and a saturating wrap tally.
module param_mod_counter
   import pmc_pkg::*;
#(
   parameter int WIDTH    = 3,
   parameter int MODULUS  = 6,
   parameter int SATURATE = 0,
   parameter int PRESCALE = 1,
   parameter int TALLY_W  = 8
) (
   input  logic               CLK,
   input  logic               RSTN,
   input  logic               CLEAR,
   input  logic               LOAD,
   input  logic [WIDTH-1:0]   LOAD_VAL,
   input  logic               UP_ENABLE,
   input  logic               DOWN_ENABLE,
   output logic [WIDTH-1:0]   CNT,
   output logic               AT_MAX,
   output logic               AT_MIN,
   output logic               WRAP,
   output logic [TALLY_W-1:0] WRAP_TALLY
);

   // Parameter legality is enforced at elaboration time.
   if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $fatal(1, "param_mod_counter: WIDTH out of range 2..16");
   end
   if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
      $fatal(1, "param_mod_counter: MODULUS out of range 2..2**WIDTH");
   end
   if (SATURATE != 0 && SATURATE != 1) begin : g_bad_saturate
      $fatal(1, "param_mod_counter: SATURATE must be 0 or 1");
   end
   if (TALLY_W < 1) begin : g_bad_tally
      $fatal(1, "param_mod_counter: TALLY_W must be at least 1");
   end

   // Compares run one bit wider than the count so MODULUS == 2**WIDTH
   // is representable and no check relies on natural overflow.
   localparam int AW = WIDTH + 1;
   localparam logic [AW-1:0]    MOD_W   = AW'(MODULUS);
   localparam logic [AW-1:0]    MAX_W   = AW'(MODULUS - 1);
   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0]   r_cnt;
   logic               r_wrap;
   logic [TALLY_W-1:0] r_tally;

   dir_e               w_dir;
   logic               w_active;
   logic               w_tick;
   logic               w_pre_clear;
   logic [AW-1:0]      w_cnt_ext;
   logic               w_oob;
   logic               w_at_max;
   logic               w_at_min;
   logic [WIDTH-1:0]   w_load_val;
   logic [WIDTH-1:0]   w_cnt_nxt;
   logic               w_wrap_nxt;
   logic               w_tally_clr;
   logic               w_tally_inc;

   assign w_cnt_ext   = {1'b0, r_cnt};
   assign w_oob       = (w_cnt_ext >= MOD_W);
   assign w_at_max    = (w_cnt_ext == MAX_W);
   assign w_at_min    = (r_cnt == '0);
   assign w_active    = (w_dir != DIR_IDLE);
   assign w_pre_clear = CLEAR | LOAD;

   // Decode the step direction for this cycle.
   always_comb begin
      w_dir = dir_decode(UP_ENABLE, DOWN_ENABLE);
   end

   // Load value clamped into the legal count range.
   always_comb begin
      w_load_val = WIDTH'(clamp_mod(PMC_AW'(LOAD_VAL), PMC_AW'(MODULUS)));
   end

   pmc_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .CLK      (CLK),
      .RSTN     (RSTN),
      .i_active (w_active),
      .i_clear  (w_pre_clear),
      .o_tick   (w_tick)
   );

   // Next count and wrap: recovery > clear > load > step > hold.
   always_comb begin
      w_cnt_nxt   = r_cnt;
      w_wrap_nxt  = 1'b0;
      w_tally_clr = 1'b0;
      w_tally_inc = 1'b0;
      if (w_oob) begin
         w_cnt_nxt = '0;
         if (CLEAR) w_tally_clr = 1'b1;
      end else if (CLEAR) begin
         w_cnt_nxt   = '0;
         w_tally_clr = 1'b1;
      end else if (LOAD) begin
         w_cnt_nxt = w_load_val;
      end else if (w_tick) begin
         if (w_dir == DIR_UP) begin
            if (!w_at_max) begin
               w_cnt_nxt = r_cnt + WIDTH'(1);
            end else if (SATURATE == 0) begin
               w_cnt_nxt   = '0;
               w_wrap_nxt  = 1'b1;
               w_tally_inc = 1'b1;
            end
         end else if (w_dir == DIR_DN) begin
            if (!w_at_min) begin
               w_cnt_nxt = r_cnt - WIDTH'(1);
            end else if (SATURATE == 0) begin
               w_cnt_nxt   = MAX_CNT;
               w_wrap_nxt  = 1'b1;
               w_tally_inc = 1'b1;
            end
         end
      end
   end

   // Count and wrap pulse registers.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_cnt  <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_wrap <= w_wrap_nxt;
      end
   end

   // Wrap tally: cleared with the count, sticks at all-ones.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_tally <= '0;
      end else if (w_tally_clr) begin
         r_tally <= '0;
      end else if (w_tally_inc && (r_tally != '1)) begin
         r_tally <= r_tally + TALLY_W'(1);
      end
   end

   assign CNT        = r_cnt;
   assign AT_MAX     = w_at_max;
   assign AT_MIN     = w_at_min;
   assign WRAP       = r_wrap;
   assign WRAP_TALLY = r_tally;

endmodule

// File: tb/tb_param_mod_counter.sv
// Directed bench for param_mod_counter. Four instances share one set of
// inputs: defaults, saturating, prescale-by-3 and modulus-8/2-bit tally.
module tb_param_mod_counter;

   logic       CLK = 1'b0;
   logic       RSTN = 1'b0;
   logic       CLEAR = 1'b0;
   logic       LOAD = 1'b0;
   logic [2:0] LOAD_VAL = 3'd0;
   logic       UP_ENABLE = 1'b0;
   logic       DOWN_ENABLE = 1'b0;

   logic [2:0] d_cnt, s_cnt, p_cnt, m_cnt;
   logic       d_max, s_max, p_max, m_max;
   logic       d_min, s_min, p_min, m_min;
   logic       d_wrap, s_wrap, p_wrap, m_wrap;
   logic [7:0] d_tally, s_tally, p_tally;
   logic [1:0] m_tally;

   int total = 0;
   int bad = 0;

   always #5 CLK = ~CLK;

   param_mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(0), .PRESCALE(1), .TALLY_W(8)) u_def (
      .CLK(CLK), .RSTN(RSTN), .CLEAR(CLEAR), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
      .UP_ENABLE(UP_ENABLE), .DOWN_ENABLE(DOWN_ENABLE),
      .CNT(d_cnt), .AT_MAX(d_max), .AT_MIN(d_min), .WRAP(d_wrap), .WRAP_TALLY(d_tally));

   param_mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1), .PRESCALE(1), .TALLY_W(8)) u_sat (
      .CLK(CLK), .RSTN(RSTN), .CLEAR(CLEAR), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
      .UP_ENABLE(UP_ENABLE), .DOWN_ENABLE(DOWN_ENABLE),
      .CNT(s_cnt), .AT_MAX(s_max), .AT_MIN(s_min), .WRAP(s_wrap), .WRAP_TALLY(s_tally));

   param_mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(0), .PRESCALE(3), .TALLY_W(8)) u_pre (
      .CLK(CLK), .RSTN(RSTN), .CLEAR(CLEAR), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
      .UP_ENABLE(UP_ENABLE), .DOWN_ENABLE(DOWN_ENABLE),
      .CNT(p_cnt), .AT_MAX(p_max), .AT_MIN(p_min), .WRAP(p_wrap), .WRAP_TALLY(p_tally));

   param_mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0), .PRESCALE(1), .TALLY_W(2)) u_m8 (
      .CLK(CLK), .RSTN(RSTN), .CLEAR(CLEAR), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
      .UP_ENABLE(UP_ENABLE), .DOWN_ENABLE(DOWN_ENABLE),
      .CNT(m_cnt), .AT_MAX(m_max), .AT_MIN(m_min), .WRAP(m_wrap), .WRAP_TALLY(m_tally));

   // Advance one clock and settle just past the edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      CLEAR = 0; LOAD = 0; LOAD_VAL = 0; UP_ENABLE = 0; DOWN_ENABLE = 0;
      RSTN = 0;
      step();
      step();
      total++; if (d_cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", d_cnt); end
      total++; if (d_min !== 1'b1) begin bad++; $display("FAIL reset_at_min got=%b want=1", d_min); end
      total++; if (d_max !== 1'b0) begin bad++; $display("FAIL reset_at_max got=%b want=0", d_max); end
      total++; if (d_wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b want=0", d_wrap); end
      total++; if (d_tally !== 8'd0) begin bad++; $display("FAIL reset_tally got=%0d want=0", d_tally); end
      RSTN = 1;
   endtask

   task automatic test_up_wrap();
      int exp_cnt[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
      test_reset();
      UP_ENABLE = 1;
      for (int i = 0; i < 8; i++) begin
         step();
         total++; if (d_cnt !== 3'(exp_cnt[i])) begin bad++; $display("FAIL up_cnt[%0d] got=%0d want=%0d", i, d_cnt, exp_cnt[i]); end
         total++; if (d_wrap !== (i == 5)) begin bad++; $display("FAIL up_wrap[%0d] got=%b want=%b", i, d_wrap, (i == 5)); end
      end
      total++; if (d_tally !== 8'd1) begin bad++; $display("FAIL up_tally got=%0d want=1", d_tally); end
      UP_ENABLE = 0;
   endtask

   task automatic test_down_and_conflict();
      test_reset();
      DOWN_ENABLE = 1;
      step();
      total++; if (d_cnt !== 3'd5) begin bad++; $display("FAIL dn_cnt0 got=%0d want=5", d_cnt); end
      total++; if (d_wrap !== 1'b1) begin bad++; $display("FAIL dn_wrap0 got=%b want=1", d_wrap); end
      total++; if (d_max !== 1'b1) begin bad++; $display("FAIL dn_at_max got=%b want=1", d_max); end
      step();
      total++; if (d_cnt !== 3'd4) begin bad++; $display("FAIL dn_cnt1 got=%0d want=4", d_cnt); end
      total++; if (d_wrap !== 1'b0) begin bad++; $display("FAIL dn_wrap1 got=%b want=0", d_wrap); end
      total++; if (p_cnt !== 3'd0) begin bad++; $display("FAIL dn_pre_cnt1 got=%0d want=0", p_cnt); end
      UP_ENABLE = 1;
      for (int i = 0; i < 2; i++) begin
         step();
         total++; if (d_cnt !== 3'd4) begin bad++; $display("FAIL both_hold[%0d] got=%0d want=4", i, d_cnt); end
         total++; if (p_cnt !== 3'd0) begin bad++; $display("FAIL both_pre_hold[%0d] got=%0d want=0", i, p_cnt); end
      end
      UP_ENABLE = 0;
      step();
      total++; if (d_cnt !== 3'd3) begin bad++; $display("FAIL dn_cnt2 got=%0d want=3", d_cnt); end
      total++; if (p_cnt !== 3'd5) begin bad++; $display("FAIL dn_pre_step got=%0d want=5", p_cnt); end
      total++; if (p_wrap !== 1'b1) begin bad++; $display("FAIL dn_pre_wrap got=%b want=1", p_wrap); end
      DOWN_ENABLE = 0;
   endtask

   task automatic test_saturate();
      int e;
      test_reset();
      UP_ENABLE = 1;
      for (int i = 0; i < 10; i++) begin
         step();
         e = (i + 1 > 5) ? 5 : i + 1;
         total++; if (s_cnt !== 3'(e)) begin bad++; $display("FAIL sat_up_cnt[%0d] got=%0d want=%0d", i, s_cnt, e); end
         total++; if (s_wrap !== 1'b0) begin bad++; $display("FAIL sat_up_wrap[%0d] got=%b want=0", i, s_wrap); end
      end
      total++; if (s_max !== 1'b1) begin bad++; $display("FAIL sat_at_max got=%b want=1", s_max); end
      UP_ENABLE = 0;
      DOWN_ENABLE = 1;
      for (int i = 0; i < 10; i++) begin
         step();
         e = (4 - i < 0) ? 0 : 4 - i;
         total++; if (s_cnt !== 3'(e)) begin bad++; $display("FAIL sat_dn_cnt[%0d] got=%0d want=%0d", i, s_cnt, e); end
         total++; if (s_wrap !== 1'b0) begin bad++; $display("FAIL sat_dn_wrap[%0d] got=%b want=0", i, s_wrap); end
      end
      total++; if (s_min !== 1'b1) begin bad++; $display("FAIL sat_at_min got=%b want=1", s_min); end
      total++; if (s_tally !== 8'd0) begin bad++; $display("FAIL sat_tally got=%0d want=0", s_tally); end
      DOWN_ENABLE = 0;
   endtask

   task automatic test_load();
      test_reset();
      LOAD = 1; LOAD_VAL = 3'd7;
      step();
      total++; if (d_cnt !== 3'd5) begin bad++; $display("FAIL load_clamp got=%0d want=5", d_cnt); end
      total++; if (m_cnt !== 3'd7) begin bad++; $display("FAIL load_noclamp got=%0d want=7", m_cnt); end
      total++; if (d_wrap !== 1'b0) begin bad++; $display("FAIL load_wrap got=%b want=0", d_wrap); end
      LOAD = 0; UP_ENABLE = 1;
      step();
      total++; if (d_tally !== 8'd1) begin bad++; $display("FAIL load_pre_tally got=%0d want=1", d_tally); end
      UP_ENABLE = 0; LOAD = 1; LOAD_VAL = 3'd4;
      step();
      total++; if (d_cnt !== 3'd4) begin bad++; $display("FAIL load_val4 got=%0d want=4", d_cnt); end
      total++; if (d_tally !== 8'd1) begin bad++; $display("FAIL load_tally_kept got=%0d want=1", d_tally); end
      CLEAR = 1; LOAD_VAL = 3'd3;
      step();
      total++; if (d_cnt !== 3'd0) begin bad++; $display("FAIL clear_over_load got=%0d want=0", d_cnt); end
      total++; if (d_tally !== 8'd0) begin bad++; $display("FAIL clear_tally got=%0d want=0", d_tally); end
      CLEAR = 0; LOAD_VAL = 3'd2; UP_ENABLE = 1;
      step();
      total++; if (d_cnt !== 3'd2) begin bad++; $display("FAIL load_over_up got=%0d want=2", d_cnt); end
      LOAD = 0;
      step();
      total++; if (d_cnt !== 3'd3) begin bad++; $display("FAIL up_after_load got=%0d want=3", d_cnt); end
      UP_ENABLE = 0;
   endtask

   task automatic test_prescale();
      logic up_pat[11]  = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
      int   exp_cnt[11] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};
      test_reset();
      for (int i = 0; i < 11; i++) begin
         UP_ENABLE = up_pat[i];
         step();
         total++; if (p_cnt !== 3'(exp_cnt[i])) begin bad++; $display("FAIL pre_cnt[%0d] got=%0d want=%0d", i, p_cnt, exp_cnt[i]); end
      end
      UP_ENABLE = 0;
   endtask

   task automatic test_tally_sat_and_async_reset();
      int wraps;
      int e_tally;
      test_reset();
      wraps = 0;
      UP_ENABLE = 1;
      for (int i = 0; i < 40; i++) begin
         step();
         if ((i + 1) % 8 == 0) wraps++;
         e_tally = (wraps > 3) ? 3 : wraps;
         total++; if (m_cnt !== 3'((i + 1) % 8)) begin bad++; $display("FAIL m8_cnt[%0d] got=%0d want=%0d", i, m_cnt, (i + 1) % 8); end
         total++; if (m_wrap !== ((i + 1) % 8 == 0)) begin bad++; $display("FAIL m8_wrap[%0d] got=%b want=%b", i, m_wrap, ((i + 1) % 8 == 0)); end
         total++; if (m_tally !== 2'(e_tally)) begin bad++; $display("FAIL m8_tally[%0d] got=%0d want=%0d", i, m_tally, e_tally); end
      end
      repeat (3) step();
      total++; if (m_cnt !== 3'd3) begin bad++; $display("FAIL m8_pre_rst got=%0d want=3", m_cnt); end
      #2;
      RSTN = 0;
      #1;
      total++; if (m_cnt !== 3'd0) begin bad++; $display("FAIL async_cnt got=%0d want=0", m_cnt); end
      total++; if (m_tally !== 2'd0) begin bad++; $display("FAIL async_tally got=%0d want=0", m_tally); end
      total++; if (m_min !== 1'b1) begin bad++; $display("FAIL async_at_min got=%b want=1", m_min); end
      total++; if (p_cnt !== 3'd0) begin bad++; $display("FAIL async_pre_cnt got=%0d want=0", p_cnt); end
      #1;
      RSTN = 1;
      step();
      total++; if (m_cnt !== 3'd1) begin bad++; $display("FAIL post_rst_m8 got=%0d want=1", m_cnt); end
      total++; if (p_cnt !== 3'd0) begin bad++; $display("FAIL post_rst_pre0 got=%0d want=0", p_cnt); end
      step();
      total++; if (p_cnt !== 3'd0) begin bad++; $display("FAIL post_rst_pre1 got=%0d want=0", p_cnt); end
      step();
      total++; if (p_cnt !== 3'd1) begin bad++; $display("FAIL post_rst_pre2 got=%0d want=1", p_cnt); end
      UP_ENABLE = 0;
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_down_and_conflict();
      test_saturate();
      test_load();
      test_prescale();
      test_tally_sat_and_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
